// File: rtl/capture_pkg.sv
// Shared definitions for the multi-channel capture block: FSM encodings,
// default register addresses and a constant clog2 helper.
package capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  // Readout sub-phase inside READ: address issue, RAM data load, present to Tx
  typedef enum logic [1:0] {
    RD_ISSUE   = 2'd0,
    RD_LOAD    = 2'd1,
    RD_PRESENT = 2'd2
  } rd_phase_t;

  localparam int DEF_ADDR_CH_MASK   = 5;
  localparam int DEF_ADDR_PRE_TRIG  = 6;
  localparam int DEF_ADDR_POST_TRIG = 7;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Per-channel sample buffer: one synchronous write port and a registered
// read port with one cycle of latency.
module capture_ram
  import capture_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int DEPTH = 4096,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [BITS-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [BITS-1:0] rd_data
);

  logic [BITS-1:0] mem [DEPTH];

  // Sample write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/multi_channel_capture.sv
// N-channel pre/post-trigger capture into circular buffers with Tx readout.
// Optional build macro CAPTURE_AUTO_REARM_EN: after readout, restart FILL instead of IDLE.
module multi_channel_capture
  import capture_pkg::*;
#(
  parameter int N_CHANNELS        = 2,
  parameter int BITS_ADC          = 8,
  parameter int DEPTH             = 4096,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int REG_DATA_WIDTH    = 16,
  parameter int ADDR_CH_MASK      = DEF_ADDR_CH_MASK,
  parameter int ADDR_PRE_TRIG     = DEF_ADDR_PRE_TRIG,
  parameter int ADDR_POST_TRIG    = DEF_ADDR_POST_TRIG,
  parameter int DEFAULT_CH_MASK   = 1,
  parameter int DEFAULT_PRE_TRIG  = 0,
  parameter int DEFAULT_POST_TRIG = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CHANNELS*BITS_ADC-1:0] adc_data,
  input  logic                           adc_rdy,
  input  logic                           trigger,
  input  logic                           arm,
  input  logic [REG_ADDR_WIDTH-1:0]      register_addr,
  input  logic [REG_DATA_WIDTH-1:0]      register_data,
  input  logic                           register_rdy,
  output logic [BITS_ADC-1:0]            tx_data,
  output logic                           tx_rdy,
  output logic                           tx_eof,
  input  logic                           tx_ack,
  output logic                           busy,
  output logic                           triggered
);

  localparam int AW  = clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int CHW = (N_CHANNELS > 1) ? clog2(N_CHANNELS) : 1;

  logic [N_CHANNELS-1:0] mask_r;
  logic [CW-1:0]         pre_r;
  logic [CW-1:0]         post_r;

  logic [CW-1:0]         post_eff_s;
  logic [CW:0]           win_sum_s;
  logic [CW-1:0]         len_cfg_s;

  logic [N_CHANNELS-1:0] mask_l_r;
  logic [CW-1:0]         pre_l_r;
  logic [CW-1:0]         post_l_r;
  logic [CW-1:0]         len_l_r;

  state_t                state_r, state_s;
  rd_phase_t             phase_r, phase_s;
  logic [AW-1:0]         wr_ptr_r;
  logic [CW-1:0]         fill_cnt_r, fill_cnt_s;
  logic [CW-1:0]         post_cnt_r, post_cnt_s;
  logic [AW-1:0]         rd_start_r, rd_start_s;
  logic [AW-1:0]         rd_addr_r, rd_addr_s;
  logic [CW-1:0]         rd_cnt_r, rd_cnt_s;
  logic [CHW-1:0]        ch_r, ch_s;
  logic [BITS_ADC-1:0]   tx_data_r, tx_data_s;
  logic                  tx_rdy_r, tx_rdy_s;
  logic                  tx_eof_r, tx_eof_s;
  logic                  busy_r;
  logic                  trig_r;

  logic                  latch_s;
  logic                  finish_s;
  logic                  wr_en_s;
  logic                  last_smp_s;
  logic [AW-1:0]         ram_addr_s;
  logic [BITS_ADC-1:0]   ram_q [N_CHANNELS];
  logic [BITS_ADC-1:0]   ram_mux_s;
  logic [CHW-1:0]        first_ch_s, nxt_ch_s;
  logic                  first_vld_s, nxt_vld_s;
  logic                  unused_s;

  assign unused_s = ^register_data;

  // Configuration registers; only the low mask/count bits are kept
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_r <= N_CHANNELS'(DEFAULT_CH_MASK);
      pre_r  <= CW'(DEFAULT_PRE_TRIG);
      post_r <= CW'(DEFAULT_POST_TRIG);
    end else if (register_rdy) begin
      if (register_addr == REG_ADDR_WIDTH'(ADDR_CH_MASK)) begin
        mask_r <= register_data[N_CHANNELS-1:0];
      end
      if (register_addr == REG_ADDR_WIDTH'(ADDR_PRE_TRIG)) begin
        pre_r <= register_data[CW-1:0];
      end
      if (register_addr == REG_ADDR_WIDTH'(ADDR_POST_TRIG)) begin
        post_r <= register_data[CW-1:0];
      end
    end
  end

  // Window length from the live registers, clamped to the buffer depth
  always_comb begin
    post_eff_s = (post_r == CW'(0)) ? CW'(1) : post_r;
    win_sum_s  = {1'b0, pre_r} + {1'b0, post_eff_s};
    if (win_sum_s > (CW + 1)'(DEPTH)) begin
      len_cfg_s = CW'(DEPTH);
    end else begin
      len_cfg_s = win_sum_s[CW-1:0];
    end
  end

  // Lowest enabled channel, and the next enabled channel above ch_r
  always_comb begin
    first_ch_s  = CHW'(0);
    first_vld_s = 1'b0;
    nxt_ch_s    = CHW'(0);
    nxt_vld_s   = 1'b0;
    for (int i = N_CHANNELS - 1; i >= 0; i--) begin
      if (mask_l_r[i]) begin
        first_ch_s  = CHW'(i);
        first_vld_s = 1'b1;
      end else begin
        first_ch_s  = first_ch_s;
      end
      if (mask_l_r[i] && (CHW'(i) > ch_r)) begin
        nxt_ch_s  = CHW'(i);
        nxt_vld_s = 1'b1;
      end else begin
        nxt_ch_s  = nxt_ch_s;
      end
    end
  end

  assign wr_en_s   = adc_rdy && ((state_r == ST_FILL) || (state_r == ST_ARMED) ||
                                 (state_r == ST_POST));
  assign ram_mux_s = ram_q[ch_r];

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ram
    capture_ram #(
      .BITS  (BITS_ADC),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_ram (
      .clk     (clk),
      .we      (wr_en_s),
      .wr_addr (wr_ptr_r),
      .wr_data (adc_data[g*BITS_ADC +: BITS_ADC]),
      .rd_addr (ram_addr_s),
      .rd_data (ram_q[g])
    );
  end

  // Next-state, readout sequencing and Tx output values
  always_comb begin
    state_s    = state_r;
    phase_s    = phase_r;
    fill_cnt_s = fill_cnt_r;
    post_cnt_s = post_cnt_r;
    rd_start_s = rd_start_r;
    rd_addr_s  = rd_addr_r;
    rd_cnt_s   = rd_cnt_r;
    ch_s       = ch_r;
    tx_data_s  = tx_data_r;
    tx_rdy_s   = tx_rdy_r;
    tx_eof_s   = tx_eof_r;
    latch_s    = 1'b0;
    finish_s   = 1'b0;
    ram_addr_s = rd_addr_r;
    last_smp_s = (rd_cnt_r == (len_l_r - CW'(1)));

    case (state_r)
      ST_IDLE: begin
        if (arm) begin
          state_s    = ST_FILL;
          fill_cnt_s = CW'(0);
          latch_s    = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (pre_l_r == CW'(0)) begin
          state_s = ST_ARMED;
        end else if (adc_rdy) begin
          fill_cnt_s = fill_cnt_r + CW'(1);
          state_s    = (fill_cnt_s == pre_l_r) ? ST_ARMED : ST_FILL;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_ARMED: begin
        if (trigger) begin
          state_s    = ST_POST;
          post_cnt_s = CW'(0);
        end else begin
          state_s = ST_ARMED;
        end
      end
      ST_POST: begin
        if (adc_rdy) begin
          post_cnt_s = post_cnt_r + CW'(1);
          if (post_cnt_s == post_l_r) begin
            // wr_ptr_r + 1 is the pointer after this final post-trigger write
            state_s    = ST_READ;
            phase_s    = RD_ISSUE;
            rd_start_s = wr_ptr_r + AW'(1) - len_l_r[AW-1:0];
            rd_cnt_s   = CW'(0);
            ch_s       = first_ch_s;
          end else begin
            state_s = ST_POST;
          end
        end else begin
          state_s = ST_POST;
        end
      end
      ST_READ: begin
        case (phase_r)
          RD_ISSUE: begin
            if (!first_vld_s) begin
              finish_s = 1'b1;
            end else begin
              ram_addr_s = rd_start_r;
              rd_addr_s  = rd_start_r;
              phase_s    = RD_LOAD;
            end
          end
          RD_LOAD: begin
            tx_data_s = ram_mux_s;
            tx_rdy_s  = 1'b1;
            tx_eof_s  = last_smp_s && !nxt_vld_s;
            phase_s   = RD_PRESENT;
          end
          RD_PRESENT: begin
            if (tx_ack) begin
              tx_rdy_s = 1'b0;
              tx_eof_s = 1'b0;
              phase_s  = RD_LOAD;
              if (!last_smp_s) begin
                rd_cnt_s   = rd_cnt_r + CW'(1);
                ram_addr_s = rd_addr_r + AW'(1);
                rd_addr_s  = rd_addr_r + AW'(1);
              end else if (nxt_vld_s) begin
                ch_s       = nxt_ch_s;
                rd_cnt_s   = CW'(0);
                ram_addr_s = rd_start_r;
                rd_addr_s  = rd_start_r;
              end else begin
                finish_s = 1'b1;
              end
            end else begin
              phase_s = RD_PRESENT;
            end
          end
          default: begin
            phase_s = RD_ISSUE;
          end
        endcase
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (finish_s) begin
`ifdef CAPTURE_AUTO_REARM_EN
      state_s    = ST_FILL;
      fill_cnt_s = CW'(0);
      latch_s    = 1'b1;
`else
      state_s    = ST_IDLE;
`endif
      phase_s    = RD_ISSUE;
    end else begin
      phase_s    = phase_s;
    end
  end

  // State, pointers, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      phase_r    <= RD_ISSUE;
      wr_ptr_r   <= AW'(0);
      fill_cnt_r <= CW'(0);
      post_cnt_r <= CW'(0);
      rd_start_r <= AW'(0);
      rd_addr_r  <= AW'(0);
      rd_cnt_r   <= CW'(0);
      ch_r       <= CHW'(0);
      tx_data_r  <= BITS_ADC'(0);
      tx_rdy_r   <= 1'b0;
      tx_eof_r   <= 1'b0;
      busy_r     <= 1'b0;
      trig_r     <= 1'b0;
      mask_l_r   <= N_CHANNELS'(0);
      pre_l_r    <= CW'(0);
      post_l_r   <= CW'(0);
      len_l_r    <= CW'(0);
    end else begin
      state_r    <= state_s;
      phase_r    <= phase_s;
      fill_cnt_r <= fill_cnt_s;
      post_cnt_r <= post_cnt_s;
      rd_start_r <= rd_start_s;
      rd_addr_r  <= rd_addr_s;
      rd_cnt_r   <= rd_cnt_s;
      ch_r       <= ch_s;
      tx_data_r  <= tx_data_s;
      tx_rdy_r   <= tx_rdy_s;
      tx_eof_r   <= tx_eof_s;
      busy_r     <= (state_s != ST_IDLE);
      trig_r     <= (state_s == ST_POST) || (state_s == ST_READ);
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (latch_s) begin
        mask_l_r <= mask_r;
        pre_l_r  <= pre_r;
        post_l_r <= post_eff_s;
        len_l_r  <= len_cfg_s;
      end
    end
  end

  assign tx_data   = tx_data_r;
  assign tx_rdy    = tx_rdy_r;
  assign tx_eof    = tx_eof_r;
  assign busy      = busy_r;
  assign triggered = trig_r;

endmodule

// File: tb/tb_multi_channel_capture.sv
// Directed, table-driven bench for multi_channel_capture (2 channels, depth 16).
module tb_multi_channel_capture;

  localparam int N = 2;
  localparam int B = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N*B-1:0] adc_data = '0;
  logic         adc_rdy = 1'b0;
  logic         trigger = 1'b0;
  logic         arm = 1'b0;
  logic [7:0]   register_addr = 8'd0;
  logic [15:0]  register_data = 16'd0;
  logic         register_rdy = 1'b0;
  logic [B-1:0] tx_data;
  logic         tx_rdy;
  logic         tx_eof;
  logic         tx_ack = 1'b0;
  logic         busy;
  logic         triggered;

  always #5 clk = ~clk;

  multi_channel_capture #(.N_CHANNELS(N), .BITS_ADC(B), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_rdy(adc_rdy),
    .trigger(trigger), .arm(arm), .register_addr(register_addr),
    .register_data(register_data), .register_rdy(register_rdy),
    .tx_data(tx_data), .tx_rdy(tx_rdy), .tx_eof(tx_eof), .tx_ack(tx_ack),
    .busy(busy), .triggered(triggered)
  );

  typedef struct {
    logic [1:0] mask;
    int         pre;
    int         post;
    int         trig_k;
    bit         ign;
    int         start;
    int         len;
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   k        = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] ramp(input int c, input int kk);
    logic [7:0] v;
    v = 8'(kk);
    return (c == 1) ? v + 8'h80 : v;
  endfunction

  task automatic reg_write(input int a, input int d);
    register_addr = 8'(a);
    register_data = 16'(d);
    register_rdy  = 1'b1;
    tick();
    register_rdy  = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic push(input bit trig, input bit arm_in);
    adc_data = {ramp(1, k), ramp(0, k)};
    adc_rdy  = 1'b1;
    trigger  = trig;
    arm      = arm_in;
    tick();
    adc_rdy  = 1'b0;
    trigger  = 1'b0;
    arm      = 1'b0;
    k++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Return the DUT to IDLE when it re-arms itself after a capture
  task automatic end_capture();
`ifdef CAPTURE_AUTO_REARM_EN
    do_reset();
`endif
  endtask

  // Drain one capture: expected stream built from mask, window start and length
  task automatic collect(input logic [1:0] mask, input int start, input int len);
    logic [7:0] exp_q[$];
    int n;
    int waitc;
    for (int c = 0; c < N; c++)
      if (mask[c])
        for (int i = 0; i < len; i++) exp_q.push_back(ramp(c, start + i));
    n = exp_q.size();
    for (int j = 0; j < n; j++) begin
      waitc = 0;
      while (!tx_rdy && waitc < 60) begin
        tick();
        waitc++;
      end
      if (!tx_rdy) begin
        n_checks++;
        $display("FAIL rdy_timeout: transfer %0d of %0d never presented", j, n);
        return;
      end
      if (j == 0) chk("first_latency", waitc, 2);
      else        chk("gap_cycles", waitc, 1);
      chk("data", tx_data, exp_q[j]);
      chk("eof", tx_eof, (j == n - 1));
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      chk("rdy_drop", tx_rdy, 0);
    end
`ifdef CAPTURE_AUTO_REARM_EN
    chk("busy_after_eof_rearm", busy, 1);
    chk("triggered_cleared_rearm", triggered, 0);
`else
    chk("busy_after_eof", busy, 0);
`endif
  endtask

  task automatic run_vec(input vec_t v);
    int post_eff;
    int total;
    reg_write(5, v.mask);
    reg_write(6, v.pre);
    reg_write(7, v.post);
    pulse_arm();
    chk("busy_after_arm", busy, 1);
    k = 0;
    post_eff = (v.post == 0) ? 1 : v.post;
    total = v.trig_k + 1 + post_eff;
    for (int s = 0; s < total; s++) begin
      push((s == v.trig_k) || (v.ign && s == 2), v.ign && s == 4);
      if (v.ign && s == 2) chk("trig_in_fill_ignored", triggered, 0);
      if (s == v.trig_k)   chk("triggered_set", triggered, 1);
    end
    collect(v.mask, v.start, v.len);
    end_capture();
  endtask

  initial begin
    vecs[0] = '{mask: 2'b11, pre: 4,  post: 4, trig_k: 9,  ign: 1'b0, start: 6,  len: 8};
    vecs[1] = '{mask: 2'b11, pre: 4,  post: 4, trig_k: 5,  ign: 1'b1, start: 2,  len: 8};
    vecs[2] = '{mask: 2'b01, pre: 12, post: 8, trig_k: 20, ign: 1'b0, start: 13, len: 16};
    vecs[3] = '{mask: 2'b10, pre: 4,  post: 4, trig_k: 9,  ign: 1'b0, start: 6,  len: 8};
    vecs[4] = '{mask: 2'b11, pre: 3,  post: 0, trig_k: 5,  ign: 1'b0, start: 3,  len: 4};
    vecs[5] = '{mask: 2'b01, pre: 0,  post: 3, trig_k: 2,  ign: 1'b0, start: 3,  len: 3};

    // Reset values, then a capture with default registers (LEN = 1)
    do_reset();
    chk("rst_tx_rdy", tx_rdy, 0);
    chk("rst_tx_eof", tx_eof, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_triggered", triggered, 0);
    pulse_arm();
    tick();
    k = 0;
    push(1'b1, 1'b0);
    chk("default_triggered", triggered, 1);
    push(1'b0, 1'b0);
    collect(2'b01, 1, 1);
    end_capture();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Empty mask: READ exits without presenting anything
    reg_write(5, 0);
    reg_write(6, 2);
    reg_write(7, 2);
    pulse_arm();
    k = 0;
    for (int s = 0; s < 5; s++) push(s == 2, 1'b0);
    chk("mask0_rdy_t0", tx_rdy, 0);
    tick();
    chk("mask0_rdy_t1", tx_rdy, 0);
`ifdef CAPTURE_AUTO_REARM_EN
    chk("mask0_busy_rearm", busy, 1);
`else
    chk("mask0_busy", busy, 0);
`endif
    end_capture();

    // Back-pressure on the first sample, then reset in the middle of READ
    reg_write(5, 1);
    reg_write(6, 2);
    reg_write(7, 2);
    pulse_arm();
    k = 0;
    for (int s = 0; s < 6; s++) push(s == 3, 1'b0);
    tick();
    tick();
    chk("bp_first_rdy", tx_rdy, 1);
    chk("bp_first_data", tx_data, 8'd2);
    for (int h = 0; h < 5; h++) begin
      tick();
      chk("bp_hold_rdy", tx_rdy, 1);
      chk("bp_hold_data", tx_data, 8'd2);
      chk("bp_hold_eof", tx_eof, 0);
    end
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    tick();
    chk("bp_second_rdy", tx_rdy, 1);
    chk("bp_second_data", tx_data, 8'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_tx_rdy", tx_rdy, 0);
    chk("abort_busy", busy, 0);
    chk("abort_triggered", triggered, 0);
    chk("abort_tx_data", tx_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_channel_capture.md
Name: multi_channel_capture

Overview:
- N-channel successor to the single-channel ADC/RAM/Tx path.
- Takes N already-digitised ADC sample streams that share one sample strobe and stores them in per-channel circular buffers.
- Captures a pre-/post-trigger window around a trigger strobe, then streams the window out over the Tx protocol, channel by channel.
- Sits between the ADC blocks / trigger source selector and the Tx protocol mux. It is configured over the simple register bus.

Parameters:
- N_CHANNELS, 2, number of channels (1..8).
- BITS_ADC, 8, sample width; also the tx_data width.
- DEPTH, 4096, samples per channel buffer; must be a power of 2.
- REG_ADDR_WIDTH, 8, register bus address width.
- REG_DATA_WIDTH, 16, register bus data width.
- ADDR_CH_MASK, 5, address of the channel-enable mask register (bit i = channel i).
- ADDR_PRE_TRIG, 6, address of the pre-trigger sample count register.
- ADDR_POST_TRIG, 7, address of the post-trigger sample count register.
- DEFAULT_CH_MASK, 1, reset value of the mask register.
- DEFAULT_PRE_TRIG, 0, reset value of the pre-trigger count.
- DEFAULT_POST_TRIG, 1, reset value of the post-trigger count.

Ports:
- clk  in  1  system clock; the block has one clock.
- rst  in  1  reset, synchronous, active-high.
- adc_data  in  N_CHANNELS*BITS_ADC  samples; channel i is at [i*BITS_ADC +: BITS_ADC].
- adc_rdy  in  1  one-cycle strobe: all channels carry a valid sample this cycle.
- trigger  in  1  one-cycle trigger strobe from the trigger source selector.
- arm  in  1  one-cycle strobe that starts a capture.
- register_addr  in  REG_ADDR_WIDTH  register bus address.
- register_data  in  REG_DATA_WIDTH  register bus data.
- register_rdy  in  1  register bus write strobe.
- tx_data  out  BITS_ADC  readout sample.
- tx_rdy  out  1  tx_data is valid.
- tx_eof  out  1  last sample of the whole capture; qualified by tx_rdy.
- tx_ack  in  1  consumer accepts tx_data.
- busy  out  1  high in every state except IDLE.
- triggered  out  1  high from trigger acceptance until the block returns to IDLE.

Behaviour:
- Registers: write when register_rdy=1 and register_addr matches. Only the low N_CHANNELS mask bits and the low log2(DEPTH)+1 count bits are used. Register writes while busy take effect at the next arm.
- Window length: LEN = min(PRE+POST, DEPTH), latched at arm. If POST is 0, it is treated as 1.
- Reset: FSM=IDLE; wr_ptr=0; counters=0; registers=defaults.
- Output reset values: tx_rdy=0, tx_eof=0, tx_data=0, busy=0, triggered=0.
- Reset mid-operation aborts the capture; the outputs take their reset values on the next edge.
- Write path: every adc_rdy in FILL, ARMED and POST writes all channels at wr_ptr, then wr_ptr increments modulo DEPTH. All channels are written regardless of the mask.
- FSM:
  - IDLE: arm -> FILL. Clear the fill counter.
  - FILL: count written samples. When the count reaches PRE -> ARMED (immediately if PRE=0). A trigger in FILL is ignored.
  - ARMED: keep writing. trigger -> POST and set triggered. If adc_rdy and trigger occur in the same cycle, that sample counts as pre-trigger.
  - POST: after POST samples have been written -> READ. Compute start = wr_ptr - LEN (mod DEPTH).
  - READ: for each enabled channel, in ascending index order, output LEN samples starting at start. When the last enabled channel is finished -> IDLE.
  - If the mask is 0, READ -> IDLE in one cycle with no tx_rdy.
- arm outside IDLE is ignored. trigger outside ARMED is ignored.
- Readout handshake:
  - A transfer occurs when tx_rdy & tx_ack.
  - The RAM read latency is 1 cycle. After each transfer, tx_rdy is low for exactly one cycle, then the next sample is presented.
  - First tx_rdy: 2 cycles after entering READ.
  - tx_data and tx_eof are held stable while tx_rdy=1 and tx_ack=0.
  - tx_eof=1 only with the final sample of the final enabled channel.
- Arithmetic: pointers are log2(DEPTH) bits and wrap naturally. Counters are log2(DEPTH)+1 bits and never wrap.

Optional Feature:
- Macro: CAPTURE_AUTO_REARM_EN.
- Defined: after the final transfer, the FSM goes READ -> FILL (not IDLE). It re-latches the registers as on an arm, clears triggered, and keeps busy=1. In this mode an arm strobe is only needed for the first capture.
- Undefined: READ -> IDLE, as specified above.

Decomposition:
- Shared package (capture_pkg):
  - FSM state encoding (IDLE, FILL, ARMED, POST, READ);
  - default register addresses;
  - a clog2 function.
- Sub-module capture_ram: a single-port-write / registered-read buffer of BITS_ADC x DEPTH, instantiated once per channel in a generate loop. The channel readout mux lives in the top level.
- Registers reuse the existing fully_associative_register.

Test Plan (N_CHANNELS=2, DEPTH=16, ch0 sample k = k, ch1 sample k = 0x80+k):
- Reset: rst for 2 cycles -> tx_rdy=0, busy=0, triggered=0; after arm with no writes, LEN=1 (defaults).
- Basic window: MASK=3, PRE=4, POST=4, arm, ramp k=0..; trigger coincident with k=9 -> ch0 outputs 6..13, then ch1 outputs 0x86..0x8D; tx_eof only on the 16th transfer; busy drops the next cycle.
- Ignored events: trigger at k=2 during FILL -> no effect, ARMED after k=3. A second arm in ARMED -> ignored. Then trigger at k=5 -> window 2..9.
- Clamp and wrap: PRE=12, POST=8 -> LEN=16; trigger at k=20 -> ch0 outputs 13..28, each value mod 256, across the pointer wrap.
- Mask: MASK=2 -> only ch1 is streamed, 8 samples, eof on the 8th. MASK=0 -> no tx_rdy, busy falls within 2 cycles of POST completion.
- Back-pressure and abort: hold tx_ack=0 for 5 cycles -> tx_data/tx_rdy stable. Assert rst mid-READ -> tx_rdy=0 and busy=0 on the next edge. With CAPTURE_AUTO_REARM_EN -> after eof, busy stays 1 and the FSM is in FILL.
